pc_gen: RTL and testbench

- Parametrised fetch-PC generator for the IF stage. It replaces the single-redirect PC register.
- Supports multi-instruction fetch blocks and prioritised redirect sources (exception, mispredict, jump, branch prediction).
- Holds a redirect that arrives during a pipeline stall and applies it when the stall releases.
- Drives the I-cache fetch address and the IF-valid/flush signals.

---
 rtl/pc_gen.sv | 147 ++++++++++++++
 tb/tb_pc_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-PC generator for the IF stage: block-sequential fetch, prioritised redirects, and stall-held redirects.
// Optional macro PC_ALIGN_CHECK_EN adds the adef output that flags misaligned redirect/predict targets.
module pc_gen #(
   parameter int                PC_WIDTH    = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h1C00_0000,
   parameter int                FETCH_BYTES = 8
) (
   input  logic                cpu_clk,
   input  logic                cpu_rstn,
   input  logic                suspend,
   input  logic                inst_valid,
   input  logic                ex_redirect,
   input  logic [PC_WIDTH-1:0] ex_pc,
   input  logic                pred_error,
   input  logic [PC_WIDTH-1:0] pred_pc,
   input  logic                jump_taken,
   input  logic [PC_WIDTH-1:0] jump_pc,
   input  logic                bp_taken,
   input  logic [PC_WIDTH-1:0] bp_pc,
   output logic [PC_WIDTH-1:0] pc,
   output logic                valid,
   output logic                flush_if,
   output logic                redirect_pending
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic                adef
`endif
);

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam logic [PC_WIDTH-1:0] BLK_BYTES = PC_WIDTH'(FETCH_BYTES);
   localparam logic [PC_WIDTH-1:0] BLK_MASK  = ~(BLK_BYTES - 1'b1);

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
   logic [1:0]          pend_pri_q, pend_pri_d;
   logic [1:0]          in_pri;
   logic [PC_WIDTH-1:0] in_tgt;
   logic [PC_WIDTH-1:0] seq_pc;
   logic                flush_d;
   logic                adef_q, adef_d;

   always_comb begin
      in_pri = 2'd0;
      in_tgt = '0;
      if (ex_redirect) begin
         in_pri = 2'd3;
         in_tgt = ex_pc;
      end else if (pred_error) begin
         in_pri = 2'd2;
         in_tgt = pred_pc;
      end else if (jump_taken) begin
         in_pri = 2'd1;
         in_tgt = jump_pc;
      end
   end

   // Masking before the add realigns an unaligned entry target to the next block.
   assign seq_pc = (pc_q & BLK_MASK) + BLK_BYTES;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_tgt_d = pend_tgt_q;
      pend_pri_d = pend_pri_q;
      flush_d    = 1'b0;
      adef_d     = adef_q;
      unique case (state_q)
         RUN: begin
            if (suspend) begin
               if (in_pri != 2'd0) begin
                  pend_tgt_d = in_tgt;
                  pend_pri_d = in_pri;
                  state_d    = PEND;
               end
            end else if (in_pri != 2'd0) begin
               pc_d    = in_tgt;
               flush_d = 1'b1;
               adef_d  = (in_tgt[1:0] != 2'b00);
            end else if (inst_valid && bp_taken) begin
               pc_d = bp_pc;
               if (bp_pc[1:0] != 2'b00) begin
                  adef_d = 1'b1;
               end
            end else if (inst_valid && !adef_q) begin
               pc_d = seq_pc;
            end
         end
         PEND: begin
            if (suspend) begin
               if (in_pri != 2'd0 && in_pri >= pend_pri_q) begin
                  pend_tgt_d = in_tgt;
                  pend_pri_d = in_pri;
               end
            end else begin
               if (in_pri != 2'd0 && in_pri >= pend_pri_q) begin
                  pc_d = in_tgt;
               end else begin
                  pc_d = pend_tgt_q;
               end
               adef_d     = (pc_d[1:0] != 2'b00);
               flush_d    = 1'b1;
               pend_tgt_d = '0;
               pend_pri_d = 2'd0;
               state_d    = RUN;
            end
         end
         default: state_d = RUN;
      endcase
`ifndef PC_ALIGN_CHECK_EN
      adef_d = 1'b0;
`endif
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         pend_tgt_q <= '0;
         pend_pri_q <= 2'd0;
         adef_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_tgt_q <= pend_tgt_d;
         pend_pri_q <= pend_pri_d;
         adef_q     <= adef_d;
      end
   end

   assign pc               = pc_q;
   assign flush_if         = flush_d;
   assign redirect_pending = (state_q == PEND);

`ifdef PC_ALIGN_CHECK_EN
   assign adef  = adef_q;
   assign valid = cpu_rstn & inst_valid & ~suspend & ~flush_if & ~redirect_pending & ~adef_q;
`else
   assign valid = cpu_rstn & inst_valid & ~suspend & ~flush_if & ~redirect_pending & ~adef_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the driver queues hand-computed expectations per cycle,
// and an independent monitor pops and compares them against the live DUT outputs.
module tb_pc_gen;

   localparam logic [31:0] RST_PC = 32'h1C00_0000;

   logic        cpu_clk;
   logic        cpu_rstn;
   logic        suspend;
   logic        inst_valid;
   logic        ex_redirect;
   logic [31:0] ex_pc;
   logic        pred_error;
   logic [31:0] pred_pc;
   logic        jump_taken;
   logic [31:0] jump_pc;
   logic        bp_taken;
   logic [31:0] bp_pc;
   logic [31:0] pc;
   logic        valid;
   logic        flush_if;
   logic        redirect_pending;
`ifdef PC_ALIGN_CHECK_EN
   logic        adef;
`endif

   typedef struct {
      int          step;
      logic [31:0] pc;
      logic        valid;
      logic        flush;
      logic        pend;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   stepNo = 0;

   pc_gen #(
      .PC_WIDTH   (32),
      .RESET_PC   (RST_PC),
      .FETCH_BYTES(8)
   ) dut (
      .cpu_clk         (cpu_clk),
      .cpu_rstn        (cpu_rstn),
      .suspend         (suspend),
      .inst_valid      (inst_valid),
      .ex_redirect     (ex_redirect),
      .ex_pc           (ex_pc),
      .pred_error      (pred_error),
      .pred_pc         (pred_pc),
      .jump_taken      (jump_taken),
      .jump_pc         (jump_pc),
      .bp_taken        (bp_taken),
      .bp_pc           (bp_pc),
      .pc              (pc),
      .valid           (valid),
      .flush_if        (flush_if),
      .redirect_pending(redirect_pending)
`ifdef PC_ALIGN_CHECK_EN
      ,
      .adef            (adef)
`endif
   );

   // 10 ns clock; inputs change on the falling edge, the DUT updates on the rising edge.
   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   function automatic void checkOutput(input string name, input int step,
                                       input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL step %0d %s: got 0x%08h, expected 0x%08h", step, name, actual, expected);
      end
   endfunction

   // Drive one cycle of inputs and queue what the outputs must show during that cycle.
   task automatic applyStimulus(input logic rstn_v, input logic susp_v, input logic iv_v,
                                input logic ex_v, input logic pr_v, input logic jp_v,
                                input logic bp_v, input logic [31:0] exp_pc,
                                input logic exp_valid, input logic exp_flush,
                                input logic exp_pend);
      exp_t e;
      @(negedge cpu_clk);
      cpu_rstn    = rstn_v;
      suspend     = susp_v;
      inst_valid  = iv_v;
      ex_redirect = ex_v;
      pred_error  = pr_v;
      jump_taken  = jp_v;
      bp_taken    = bp_v;
      stepNo++;
      e.step  = stepNo;
      e.pc    = exp_pc;
      e.valid = exp_valid;
      e.flush = exp_flush;
      e.pend  = exp_pend;
      expQ.push_back(e);
   endtask

   // Monitor: samples mid-low-phase, well away from the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge cpu_clk);
         #2;
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("pc", e.step, pc, e.pc);
            checkOutput("valid", e.step, {31'd0, valid}, {31'd0, e.valid});
            checkOutput("flush_if", e.step, {31'd0, flush_if}, {31'd0, e.flush});
            checkOutput("redirect_pending", e.step, {31'd0, redirect_pending}, {31'd0, e.pend});
         end
      end
   end

   initial begin
      int budget;
      cpu_rstn    = 1'b0;
      suspend     = 1'b0;
      inst_valid  = 1'b0;
      ex_redirect = 1'b0;
      pred_error  = 1'b0;
      jump_taken  = 1'b0;
      bp_taken    = 1'b0;
      ex_pc       = 32'h1C00_8000;
      pred_pc     = '0;
      jump_pc     = '0;
      bp_pc       = '0;

      //            rstn susp iv  ex  pr  jp  bp  pc            valid flush pend
      applyStimulus(0,   0,   1,  0,  0,  0,  0,  RST_PC,       0,    0,    0);
      applyStimulus(1,   0,   1,  0,  0,  0,  0,  32'h1C000000, 1,    0,    0);
      applyStimulus(1,   0,   1,  0,  0,  0,  0,  32'h1C000008, 1,    0,    0);
      bp_pc = 32'h1C000044;
      applyStimulus(1,   0,   1,  0,  0,  0,  1,  32'h1C000010, 1,    0,    0);
      applyStimulus(1,   0,   1,  0,  0,  0,  0,  32'h1C000044, 1,    0,    0);
      applyStimulus(1,   0,   0,  0,  0,  0,  0,  32'h1C000048, 0,    0,    0);

      pred_pc = 32'h1C000100;
      jump_pc = 32'h1C000400;
      applyStimulus(1,   0,   1,  1,  1,  1,  0,  32'h1C000048, 0,    1,    0);
      applyStimulus(1,   0,   1,  0,  0,  0,  0,  32'h1C008000, 1,    0,    0);

      // Stalled jump overwritten by a higher-priority mispredict, applied on release.
      jump_pc = 32'h1C000200;
      applyStimulus(1,   1,   1,  0,  0,  1,  0,  32'h1C008008, 0,    0,    0);
      pred_pc = 32'h1C000300;
      applyStimulus(1,   1,   0,  0,  1,  0,  0,  32'h1C008008, 0,    0,    1);
      applyStimulus(1,   1,   1,  0,  0,  0,  0,  32'h1C008008, 0,    0,    1);
      applyStimulus(1,   0,   1,  0,  0,  0,  1,  32'h1C008008, 0,    1,    1);
      applyStimulus(1,   0,   1,  0,  0,  0,  0,  32'h1C000300, 1,    0,    0);

      // Held exception beats a later stalled jump.
      jump_pc = 32'h1C000500;
      applyStimulus(1,   1,   0,  1,  0,  0,  0,  32'h1C000308, 0,    0,    0);
      applyStimulus(1,   1,   0,  0,  0,  1,  0,  32'h1C000308, 0,    0,    1);
      applyStimulus(1,   0,   0,  0,  0,  0,  0,  32'h1C000308, 0,    1,    1);
      applyStimulus(1,   0,   0,  0,  0,  0,  0,  32'h1C008000, 0,    0,    0);

      // Higher-priority redirect arriving on the release cycle wins over the held one.
      jump_pc = 32'h1C000600;
      applyStimulus(1,   1,   0,  0,  0,  1,  0,  32'h1C008000, 0,    0,    0);
      pred_pc = 32'h1C000700;
      applyStimulus(1,   0,   0,  0,  1,  0,  0,  32'h1C008000, 0,    1,    1);

      // Back-to-back redirects, then an unaligned target realigning on advance.
      jump_pc = 32'h1C000800;
      applyStimulus(1,   0,   0,  0,  0,  1,  0,  32'h1C000700, 0,    1,    0);
      pred_pc = 32'h1C000900;
      applyStimulus(1,   0,   1,  0,  1,  0,  0,  32'h1C000800, 0,    1,    0);
      applyStimulus(1,   0,   1,  0,  0,  0,  0,  32'h1C000900, 1,    0,    0);
      pred_pc = 32'h1C000A06;
      applyStimulus(1,   0,   0,  0,  1,  0,  0,  32'h1C000908, 0,    1,    0);
      applyStimulus(1,   0,   1,  0,  0,  0,  0,  32'h1C000A06, 1,    0,    0);
      applyStimulus(1,   0,   0,  0,  0,  0,  0,  32'h1C000A08, 0,    0,    0);

      // Wrap at the top of the address space.
      jump_pc = 32'hFFFFFFF8;
      applyStimulus(1,   0,   0,  0,  0,  1,  0,  32'h1C000A08, 0,    1,    0);
      applyStimulus(1,   0,   1,  0,  0,  0,  0,  32'hFFFFFFF8, 1,    0,    0);
      applyStimulus(1,   0,   0,  0,  0,  0,  0,  32'h00000000, 0,    0,    0);

      // bp_taken is ignored while stalled in RUN.
      applyStimulus(1,   1,   1,  0,  0,  0,  1,  32'h00000000, 0,    0,    0);
      applyStimulus(1,   0,   0,  0,  0,  0,  0,  32'h00000000, 0,    0,    0);

      // Reset while a redirect is held discards it.
      jump_pc = 32'h1C000200;
      applyStimulus(1,   1,   0,  0,  0,  1,  0,  32'h00000000, 0,    0,    0);
      applyStimulus(1,   1,   0,  0,  0,  0,  0,  32'h00000000, 0,    0,    1);
      applyStimulus(0,   1,   1,  0,  0,  0,  0,  RST_PC,       0,    0,    0);
      applyStimulus(1,   0,   0,  0,  0,  0,  0,  RST_PC,       0,    0,    0);
      applyStimulus(1,   0,   1,  0,  0,  0,  0,  RST_PC,       1,    0,    0);
      applyStimulus(1,   0,   0,  0,  0,  0,  0,  32'h1C000008, 0,    0,    0);

      budget = 20;
      while (expQ.size() != 0 && budget > 0) begin
         @(posedge cpu_clk);
         budget--;
      end
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      @(posedge cpu_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
